// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter: NUM AXI-Stream requesters share one sink,
// holding each grant until its tlast beat is accepted, with stall watchdog and packet count.
module axis_rr_packet_arbiter #(
   parameter int unsigned NUM        = 4,
   parameter int unsigned DSIZE      = 8,
   parameter int unsigned IDLE_LIMIT = 1023
) (
   input  logic                   clock,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [NUM*DSIZE-1:0]   s_tdata,
   input  logic [NUM-1:0]         s_tvalid,
   input  logic [NUM-1:0]         s_tlast,
   output logic [NUM-1:0]         s_tready,
   output logic [DSIZE-1:0]       m_tdata,
   output logic                   m_tvalid,
   output logic                   m_tlast,
   input  logic                   m_tready,
   output logic [NUM-1:0]         cur_grant,
   output logic                   busy,
   output logic                   stall_err,
   output logic [15:0]            pkt_cnt
);

   localparam int unsigned IW = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int unsigned CW = $clog2(IDLE_LIMIT + 1);
   localparam logic [CW-1:0] STALL_MAX = CW'(IDLE_LIMIT);
   localparam logic [CW-1:0] STALL_ARM = CW'(IDLE_LIMIT - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] LOCK = 1'b1;

   logic [0:0]       state;
   logic [IW-1:0]    grant_idx;
   logic [IW-1:0]    last_grant;
   logic [IW-1:0]    win_idx;
   logic [IW-1:0]    cand;
   logic             win_found;
   logic             accept_last;
   logic [CW-1:0]    stall_cnt;
   logic [DSIZE-1:0] chan_data [NUM];

   for (genvar g = 0; g < NUM; g++) begin : g_unpack
      assign chan_data[g] = s_tdata[g*DSIZE +: DSIZE];
   end

   // Search starts just after the last completed grant, so the pointer only moves on tlast.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_grant;
      cand      = '0;
      for (int unsigned k = 1; k <= NUM; k++) begin
         cand = IW'((32'(last_grant) + k) % NUM);
         if (!win_found && s_tvalid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      s_tready = '0;
      m_tdata  = '0;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      if (state == LOCK) begin
         m_tdata             = chan_data[grant_idx];
         m_tvalid            = s_tvalid[grant_idx];
         m_tlast             = s_tlast[grant_idx];
         s_tready[grant_idx] = m_tready;
      end
   end

   assign accept_last = m_tvalid & m_tready & m_tlast;
   assign busy        = (state == LOCK);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_grant  <= '0;
         grant_idx  <= '0;
         last_grant <= IW'(NUM - 1);
         stall_cnt  <= '0;
         stall_err  <= 1'b0;
         pkt_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               stall_cnt <= '0;
               if (enable && win_found) begin
                  state     <= LOCK;
                  grant_idx <= win_idx;
                  cur_grant <= NUM'(1) << win_idx;
               end
            end
            LOCK: begin
               if (accept_last) begin
                  state      <= IDLE;
                  last_grant <= grant_idx;
                  cur_grant  <= '0;
                  pkt_cnt    <= pkt_cnt + 16'd1;
                  stall_cnt  <= '0;
               end else if (s_tvalid[grant_idx]) begin
                  // Backpressure with valid high is progress-pending, not a stall.
                  stall_cnt <= '0;
               end else begin
                  if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + CW'(1);
                  if (stall_cnt >= STALL_ARM) stall_err <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed self-checking bench for axis_rr_packet_arbiter: reset, pass-through,
// round-robin order, backpressure, enable gating, stall watchdog, mid-packet reset.
module tb_axis_rr_packet_arbiter;

   localparam int unsigned NUM        = 4;
   localparam int unsigned DSIZE      = 8;
   localparam int unsigned IDLE_LIMIT = 1023;

   logic                 clock = 1'b0;
   logic                 rst_n;
   logic                 enable;
   logic [NUM*DSIZE-1:0] s_tdata;
   logic [NUM-1:0]       s_tvalid;
   logic [NUM-1:0]       s_tlast;
   logic [NUM-1:0]       s_tready;
   logic [DSIZE-1:0]     m_tdata;
   logic                 m_tvalid;
   logic                 m_tlast;
   logic                 m_tready;
   logic [NUM-1:0]       cur_grant;
   logic                 busy;
   logic                 stall_err;
   logic [15:0]          pkt_cnt;

   int checks = 0;
   int errors = 0;

   axis_rr_packet_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .IDLE_LIMIT(IDLE_LIMIT)) dut (
      .clock(clock), .rst_n(rst_n), .enable(enable),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .cur_grant(cur_grant), .busy(busy), .stall_err(stall_err), .pkt_cnt(pkt_cnt)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [7:0] d, input logic v, input logic l);
      s_tdata[ch*DSIZE +: DSIZE] = d;
      s_tvalid[ch] = v;
      s_tlast[ch]  = l;
   endtask

   task automatic apply_reset;
      rst_n = 1'b0;
      enable = 1'b0;
      s_tdata = '0;
      s_tvalid = '0;
      s_tlast = '0;
      m_tready = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      apply_reset;
      rst_n = 1'b0;
      #1;
      checks++; if (cur_grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b exp=0000", cur_grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall_err); end
      checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_pkt got=%0d exp=0", pkt_cnt); end
      enable = 1'b1; s_tvalid = 4'b1111; s_tlast = 4'b1111; s_tdata = 32'hFFFF_FFFF; m_tready = 1'b1;
      tick;
      checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL rst_sready got=%b exp=0000", s_tready); end
      checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin errors++; $display("FAIL rst_mvl got=%b%b exp=00", m_tvalid, m_tlast); end
      checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL rst_mdata got=%h exp=00", m_tdata); end
      checks++; if (cur_grant !== 4'b0000) begin errors++; $display("FAIL rst_hold_grant got=%b exp=0000", cur_grant); end
   endtask

   task automatic test_single_packet;
      logic [7:0] exp_d;
      apply_reset;
      enable = 1'b1;
      m_tready = 1'b1;
      set_ch(0, 8'hA0, 1'b1, 1'b0);
      #1;
      checks++; if (cur_grant !== 4'b0000) begin errors++; $display("FAIL sp_pre_grant got=%b exp=0000", cur_grant); end
      checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL sp_pre_ready got=%b exp=0000", s_tready); end
      tick;
      checks++; if (cur_grant !== 4'b0001) begin errors++; $display("FAIL sp_grant got=%b exp=0001", cur_grant); end
      for (int b = 0; b < 3; b++) begin
         exp_d = 8'hA0 + 8'(b);
         set_ch(0, exp_d, 1'b1, b == 2);
         #1;
         checks++; if (m_tdata !== exp_d) begin errors++; $display("FAIL sp_data got=%h exp=%h", m_tdata, exp_d); end
         checks++; if (m_tlast !== (b == 2)) begin errors++; $display("FAIL sp_last got=%b exp=%b", m_tlast, b == 2); end
         checks++; if (s_tready !== 4'b0001) begin errors++; $display("FAIL sp_ready got=%b exp=0001", s_tready); end
         tick;
      end
      set_ch(0, 8'h00, 1'b0, 1'b0);
      #1;
      checks++; if (cur_grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL sp_end got=%b/%b exp=0000/0", cur_grant, busy); end
      checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL sp_pkt got=%0d exp=1", pkt_cnt); end
   endtask

   task automatic test_round_robin;
      int g;
      logic [7:0] exp_d;
      logic [3:0] exp_g;
      apply_reset;
      enable = 1'b1;
      m_tready = 1'b1;
      for (int p = 0; p < 5; p++) begin
         g = p % 4;
         exp_g = 4'(1 << g);
         for (int c = 0; c < 4; c++) set_ch(c, 8'(c * 16), 1'b1, 1'b0);
         #1;
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_bubble got=%b exp=0", busy); end
         tick;
         for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 4; c++) set_ch(c, 8'(c * 16), 1'b1, 1'b0);
            exp_d = 8'(g * 16 + b);
            set_ch(g, exp_d, 1'b1, b == 1);
            #1;
            checks++; if (cur_grant !== exp_g) begin errors++; $display("FAIL rr_grant got=%b exp=%b", cur_grant, exp_g); end
            checks++; if (m_tdata !== exp_d) begin errors++; $display("FAIL rr_data got=%h exp=%h", m_tdata, exp_d); end
            checks++; if (m_tlast !== (b == 1)) begin errors++; $display("FAIL rr_last got=%b exp=%b", m_tlast, b == 1); end
            tick;
         end
      end
      s_tvalid = '0;
      #1;
      checks++; if (pkt_cnt !== 16'd5) begin errors++; $display("FAIL rr_pkt got=%0d exp=5", pkt_cnt); end
   endtask

   task automatic test_backpressure;
      int beat;
      int xfers;
      int cyc;
      logic [7:0] exp_d;
      logic [3:0] exp_r;
      apply_reset;
      enable = 1'b1;
      m_tready = 1'b1;
      set_ch(2, 8'h20, 1'b1, 1'b0);
      tick;
      #1;
      checks++; if (cur_grant !== 4'b0100) begin errors++; $display("FAIL bp_grant got=%b exp=0100", cur_grant); end
      beat = 0; xfers = 0; cyc = 0;
      while (beat < 4 && cyc < 20) begin
         m_tready = (cyc % 2 == 0);
         exp_d = 8'(32 + beat);
         set_ch(2, exp_d, 1'b1, beat == 3);
         set_ch(0, 8'hEE, 1'b1, cyc[0]);
         #1;
         exp_r = m_tready ? 4'b0100 : 4'b0000;
         checks++; if (s_tready !== exp_r) begin errors++; $display("FAIL bp_ready got=%b exp=%b", s_tready, exp_r); end
         checks++; if (m_tdata !== exp_d) begin errors++; $display("FAIL bp_data got=%h exp=%h", m_tdata, exp_d); end
         if (m_tvalid && m_tready) xfers++;
         tick;
         if (m_tready) beat++;
         cyc++;
      end
      set_ch(0, 8'h00, 1'b0, 1'b0);
      set_ch(2, 8'h00, 1'b0, 1'b0);
      m_tready = 1'b1;
      #1;
      checks++; if (xfers !== 4) begin errors++; $display("FAIL bp_xfers got=%0d exp=4", xfers); end
      checks++; if (cyc !== 7) begin errors++; $display("FAIL bp_cycles got=%0d exp=7", cyc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got=%b exp=0", busy); end
      checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL bp_stall got=%b exp=0", stall_err); end
      checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL bp_pkt got=%0d exp=1", pkt_cnt); end
   endtask

   task automatic test_enable_gate;
      logic [7:0] exp_d;
      apply_reset;
      enable = 1'b1;
      m_tready = 1'b1;
      for (int c = 0; c < 4; c++) set_ch(c, 8'(c * 16), 1'b1, 1'b0);
      tick;
      #1;
      checks++; if (cur_grant !== 4'b0001) begin errors++; $display("FAIL en_grant got=%b exp=0001", cur_grant); end
      for (int b = 0; b < 8; b++) begin
         if (b == 1) enable = 1'b0;
         exp_d = 8'h80 + 8'(b);
         set_ch(0, exp_d, 1'b1, b == 7);
         #1;
         checks++; if (m_tdata !== exp_d) begin errors++; $display("FAIL en_data got=%h exp=%h", m_tdata, exp_d); end
         tick;
      end
      set_ch(0, 8'h00, 1'b1, 1'b0);
      #1;
      checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL en_pkt got=%0d exp=1", pkt_cnt); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (cur_grant !== 4'b0000) begin errors++; $display("FAIL en_hold_grant got=%b exp=0000", cur_grant); end
         checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL en_hold_ready got=%b exp=0000", s_tready); end
         tick;
         #1;
      end
      enable = 1'b1;
      tick;
      #1;
      checks++; if (cur_grant !== 4'b0010) begin errors++; $display("FAIL en_next_grant got=%b exp=0010", cur_grant); end
      s_tvalid = '0;
      tick;
   endtask

   task automatic test_stall;
      apply_reset;
      enable = 1'b1;
      m_tready = 1'b1;
      set_ch(1, 8'h11, 1'b1, 1'b0);
      tick;
      #1;
      checks++; if (cur_grant !== 4'b0010) begin errors++; $display("FAIL st_grant got=%b exp=0010", cur_grant); end
      tick;
      set_ch(1, 8'h12, 1'b0, 1'b0);
      repeat (1022) tick;
      #1;
      checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL st_1022 got=%b exp=0", stall_err); end
      checks++; if (cur_grant !== 4'b0010) begin errors++; $display("FAIL st_held got=%b exp=0010", cur_grant); end
      set_ch(1, 8'h12, 1'b1, 1'b0);
      tick;
      set_ch(1, 8'h13, 1'b0, 1'b0);
      repeat (1022) tick;
      #1;
      checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL st_pre got=%b exp=0", stall_err); end
      tick;
      #1;
      checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL st_1023 got=%b exp=1", stall_err); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL st_busy got=%b exp=1", busy); end
      set_ch(1, 8'h13, 1'b1, 1'b1);
      #1;
      checks++; if (m_tlast !== 1'b1 || m_tdata !== 8'h13) begin errors++; $display("FAIL st_resume got=%b/%h exp=1/13", m_tlast, m_tdata); end
      tick;
      set_ch(1, 8'h00, 1'b0, 1'b0);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL st_done got=%b exp=0", busy); end
      checks++; if (stall_err !== 1'b1) begin errors++; $display("FAIL st_sticky got=%b exp=1", stall_err); end
      checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL st_pkt got=%0d exp=1", pkt_cnt); end
   endtask

   task automatic test_reset_mid_packet;
      enable = 1'b1;
      m_tready = 1'b1;
      for (int c = 0; c < 4; c++) set_ch(c, 8'(c * 16 + 1), 1'b1, 1'b0);
      tick;
      #1;
      checks++; if (cur_grant !== 4'b0100) begin errors++; $display("FAIL mr_grant got=%b exp=0100", cur_grant); end
      tick;
      rst_n = 1'b0;
      #1;
      checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL mr_ready got=%b exp=0000", s_tready); end
      checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin errors++; $display("FAIL mr_mvl got=%b%b exp=00", m_tvalid, m_tlast); end
      checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL mr_data got=%h exp=00", m_tdata); end
      checks++; if (cur_grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mr_grant0 got=%b/%b exp=0000/0", cur_grant, busy); end
      checks++; if (stall_err !== 1'b0 || pkt_cnt !== 16'd0) begin errors++; $display("FAIL mr_status got=%b/%0d exp=0/0", stall_err, pkt_cnt); end
      tick;
      rst_n = 1'b1;
      #1;
      checks++; if (cur_grant !== 4'b0000) begin errors++; $display("FAIL mr_release got=%b exp=0000", cur_grant); end
      tick;
      #1;
      checks++; if (cur_grant !== 4'b0001) begin errors++; $display("FAIL mr_first got=%b exp=0001", cur_grant); end
   endtask

   initial begin
      test_reset;
      test_single_packet;
      test_round_robin;
      test_backpressure;
      test_enable_gate;
      test_stall;
      test_reset_mid_packet;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one downstream AXI-Stream sink between NUM upstream requester streams.
- Once a channel is granted, it holds the grant until its tlast beat is accepted, so packets are never interleaved.
- A global enable gates new grants.
- A stall watchdog and a packet counter give sequencing status to the surrounding control logic.

Parameters:
- NUM, 4, number of requester streams (2..8).
- DSIZE, 8, tdata width per stream.
- IDLE_LIMIT, 1023, mid-packet stall cycles before stall_err sets (fits a 10-bit counter).

Ports:
- clock  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  permits new grants.
- s_tdata  in  NUM*DSIZE  requester data; channel i occupies bits [i*DSIZE +: DSIZE].
- s_tvalid  in  NUM  requester valid.
- s_tlast  in  NUM  requester last.
- s_tready  out  NUM  requester ready.
- m_tdata  out  DSIZE  downstream data.
- m_tvalid  out  1  downstream valid.
- m_tlast  out  1  downstream last.
- m_tready  in  1  downstream ready.
- cur_grant  out  NUM  one-hot active grant; all zero when idle.
- busy  out  1  high while in LOCK.
- stall_err  out  1  sticky stall flag.
- pkt_cnt  out  16  count of completed packets.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, cur_grant=0, last_grant=NUM-1, so channel 0 wins first.
  - stall counter=0, stall_err=0, pkt_cnt=0, busy=0.
  - s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0.
- FSM states: IDLE and LOCK.
- IDLE -> LOCK:
  - Condition: enable=1 and |s_tvalid.
  - Winner is the first i with s_tvalid[i]=1, searching last_grant+1, last_grant+2, ... modulo NUM.
  - cur_grant is registered, so the first beat can transfer the cycle after the request is seen. This is a 1-cycle arbitration bubble per packet.
- LOCK datapath (combinational, no added latency):
  - m_tdata/m_tvalid/m_tlast = the granted channel's signals.
  - s_tready[g] = m_tready; every other s_tready bit = 0.
- IDLE outputs: all s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0.
- LOCK -> IDLE on accepted tlast (m_tvalid & m_tready & m_tlast):
  - last_grant <= granted index; cur_grant <= 0; pkt_cnt += 1.
  - pkt_cnt wraps 16'hFFFF -> 0.
- Single-beat packet: LOCK lasts one cycle. Back-to-back packets sustain at most 1 packet per (beats+1) cycles.
- enable deasserted mid-packet: the current packet completes normally. No new grant is issued while enable=0. Pending requests keep s_tready=0.
- Requester dropping tvalid mid-packet: the grant is held indefinitely (no abort, no timeout release).
- Stall watchdog:
  - Counter counts LOCK cycles where the granted s_tvalid=0.
  - Counter clears on any granted tvalid=1 cycle and on entering IDLE.
  - When the counter reaches IDLE_LIMIT, stall_err <= 1 and the counter saturates.
  - stall_err clears only on reset.
  - Downstream backpressure (m_tready=0 with valid=1) is not a stall.
- A non-granted channel's tvalid/tlast activity has no effect during LOCK.
- The fairness pointer advances only on packet completion. Lowering enable does not move it.

Test Plan:
- Reset, then s_tvalid=4'b0001, 3-beat packet, m_tready=1 ->
  - cur_grant=0001 one cycle after the request.
  - Beats pass through unchanged; IDLE after beat 3; pkt_cnt=1.
- All four channels request continuously, 2-beat packets, m_tready=1 ->
  - Grants in order 0,1,2,3,0.
  - No beat from any channel interleaves with another packet; pkt_cnt=5 after 5 packets.
- Channel 2 granted, m_tready toggles 1/0 each cycle during a 4-beat packet ->
  - Exactly 4 beats transfer; s_tready[2] mirrors m_tready.
  - s_tready for the other channels stays 0; stall_err=0.
- enable=0 after the first beat of an 8-beat packet ->
  - The packet completes (8 beats), then stays IDLE with pending s_tvalid=1111.
  - Re-assert enable -> the next channel after the last grant is granted.
- Granted channel holds tvalid=0 for 1023 cycles mid-packet ->
  - stall_err=1 on the 1023rd cycle and stays 1 after traffic resumes and the packet completes.
  - Holding tvalid=0 for only 1022 cycles -> stall_err stays 0.
- Assert rst_n=0 mid-packet ->
  - All outputs zero immediately.
  - After release, channel 0 wins first if multiple requests are pending.
